// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder: IO register map, IO-select
// field, status-bit layout, byte type and the access decoder used by the top.
package mem_io_responder_pkg;

  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_type_t;

  // IO register map (full 32-bit byte addresses)
  localparam logic [31:0] IO_BASE = 32'h0003_0000;  // write: TX push, read: RX pop
  localparam logic [31:0] IO_HALT = 32'h0003_0004;  // write: halt,    read: status

  // Address bits [IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL select the IO space
  localparam int          IO_SEL_HI  = 17;
  localparam int          IO_SEL_LO  = 16;
  localparam logic [1:0]  IO_SEL_VAL = 2'b11;

  // Bit positions inside the status byte
  localparam int STAT_UART_FULL   = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_TX_OVERFLOW = 2;

  // What a single controller cycle asks of the responder
  typedef enum logic [2:0] {
    ACC_RAM_RD,
    ACC_RAM_WR,
    ACC_TX_PUSH,
    ACC_HALT,
    ACC_RX_POP,
    ACC_STATUS,
    ACC_IO_RD_NONE,
    ACC_IO_WR_NONE
  } access_e;

  function automatic access_e decode_access(input logic wr, input logic [31:0] addr);
    access_e acc;
    if (addr[IO_SEL_HI:IO_SEL_LO] != IO_SEL_VAL) begin
      acc = wr ? ACC_RAM_WR : ACC_RAM_RD;
    end else if (addr == IO_BASE) begin
      acc = wr ? ACC_TX_PUSH : ACC_RX_POP;
    end else if (addr == IO_HALT) begin
      acc = wr ? ACC_HALT : ACC_STATUS;
    end else begin
      acc = wr ? ACC_IO_WR_NONE : ACC_IO_RD_NONE;
    end
    return acc;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Bus bundle between the memory controller / UART side (master) and the
// responder (slave). Signal names match the responder's external port names.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  // memory controller request / read data
  logic        in_ram_write_flag;
  logic [31:0] in_ram_address;
  byte_type_t  in_ram_data;
  byte_type_t  out_ram_data;
  // transmit stream toward the UART
  logic        out_uart_full;
  logic        out_tx_valid;
  byte_type_t  out_tx_byte;
  logic        in_tx_ready;
  // receive stream from the UART
  logic        in_rx_valid;
  byte_type_t  in_rx_byte;
  // program stop request
  logic        out_halt;

  modport master (
    output in_ram_write_flag, in_ram_address, in_ram_data, in_tx_ready,
           in_rx_valid, in_rx_byte,
    input  out_ram_data, out_uart_full, out_tx_valid, out_tx_byte, out_halt
  );

  modport slave (
    input  in_ram_write_flag, in_ram_address, in_ram_data, in_tx_ready,
           in_rx_valid, in_rx_byte,
    output out_ram_data, out_uart_full, out_tx_valid, out_tx_byte, out_halt
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: synchronous byte FIFO, power-of-two DEPTH. Pointers wrap modulo
// DEPTH; the count carries one extra bit so full and empty are distinct.
// A push while full is accepted only when a pop happens in the same cycle.
// dout shows the head byte, forced to 0 while empty.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  byte_type_t                 din,
  input  logic                       pop,
  output byte_type_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  byte_type_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count      = count_q;
  assign count_next = count_d;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  // Next-state pointers and occupancy from the accepted push/pop
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the pointers alone define which entries are valid.
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus a small IO space (UART TX/RX FIFOs,
// status, halt) behind a 1-cycle-latency memory-controller port.
// Optional feature macro: RESPONDER_RX_EN compiles in the UART receive FIFO;
// without it RX inputs are ignored and RX reads return 0.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 4
) (
  input logic               clk,
  input logic               rst,
  mem_io_responder_if.slave bus
);

  localparam int TX_CNT_W = $clog2(TX_DEPTH) + 1;
  // Full flag threshold leaves one slot for a byte already in flight
  localparam logic [TX_CNT_W-1:0] TX_FULL_MARK = TX_CNT_W'(TX_DEPTH - 1);

  access_e                 acc;
  logic [RAM_ADDR_W-1:0]   ram_idx;
  byte_type_t              ram [2**RAM_ADDR_W];
  byte_type_t              status;

  logic                    tx_push, tx_pop, tx_full, tx_empty;
  byte_type_t              tx_head;
  logic [TX_CNT_W-1:0]     tx_count, tx_count_next;

  logic                    rx_pop, rx_nonempty;
  byte_type_t              rx_head;

  byte_type_t              rdata_q, rdata_d;
  logic                    uart_full_q, uart_full_d;
  logic                    halt_q, halt_d;
  logic                    tx_overflow_q, tx_overflow_d;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_push),
    .din        (bus.in_ram_data),
    .pop        (tx_pop),
    .dout       (tx_head),
    .full       (tx_full),
    .empty      (tx_empty),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

`ifdef RESPONDER_RX_EN
  localparam int RX_CNT_W = $clog2(RX_DEPTH) + 1;
  logic                rx_full, rx_empty;
  logic [RX_CNT_W-1:0] rx_count, rx_count_next;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.in_rx_valid),
    .din        (bus.in_rx_byte),
    .pop        (rx_pop),
    .dout       (rx_head),
    .full       (rx_full),
    .empty      (rx_empty),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  assign rx_nonempty = ~rx_empty;

  logic unused_rx;
  assign unused_rx = ^{rx_full, rx_count, rx_count_next};
`else
  // No receive path: RX reads see an empty FIFO
  assign rx_head     = '0;
  assign rx_nonempty = 1'b0;

  logic unused_rx;
  assign unused_rx = ^{bus.in_rx_valid, bus.in_rx_byte, rx_pop};
`endif

  logic unused_tx;
  assign unused_tx = ^tx_count;

  // Decode the request and compute the next read byte and sticky flags
  always_comb begin
    acc      = decode_access(bus.in_ram_write_flag, bus.in_ram_address);
    ram_idx  = bus.in_ram_address[RAM_ADDR_W-1:0];
    tx_push  = (acc == ACC_TX_PUSH);
    tx_pop   = ~tx_empty & bus.in_tx_ready;
    rx_pop   = (acc == ACC_RX_POP);

    status                   = '0;
    status[STAT_UART_FULL]   = uart_full_q;
    status[STAT_RX_NONEMPTY] = rx_nonempty;
    status[STAT_TX_OVERFLOW] = tx_overflow_q;

    rdata_d = rdata_q;
    unique case (acc)
      ACC_RAM_RD:     rdata_d = ram[ram_idx];
      ACC_RX_POP:     rdata_d = rx_head;
      ACC_STATUS:     rdata_d = status;
      ACC_IO_RD_NONE: rdata_d = '0;
      default:        rdata_d = rdata_q;   // write cycles hold the read byte
    endcase

    tx_overflow_d = tx_overflow_q | (tx_push & tx_full & ~tx_pop);
    halt_d        = halt_q | (acc == ACC_HALT);
    uart_full_d   = (tx_count_next >= TX_FULL_MARK);
  end

  // Output and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q       <= '0;
      uart_full_q   <= 1'b0;
      halt_q        <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      uart_full_q   <= uart_full_d;
      halt_q        <= halt_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  // RAM write port; a read of the same address next cycle sees the new byte
  always_ff @(posedge clk) begin
    if (acc == ACC_RAM_WR) ram[ram_idx] <= bus.in_ram_data;
  end

  assign bus.out_ram_data  = rdata_q;
  assign bus.out_uart_full = uart_full_q;
  assign bus.out_tx_valid  = ~tx_empty;
  assign bus.out_tx_byte   = tx_head;
  assign bus.out_halt      = halt_q;

endmodule
